// File: rtl/kbd_io_pkg.sv
// kbd_io_pkg
// Shared definitions for the keyboard-to-memory bridge: PS/2 prefix codes,
// bit positions inside a 16-bit key event, the writer FSM state encoding,
// and a helper that packs a key event word.
package kbd_io_pkg;

   localparam logic [7:0] KC_BREAK = 8'hF0;
   localparam logic [7:0] KC_EXT   = 8'hE0;

   // Key event layout: {rel, ext, 6'b0, code}
   localparam int EV_REL      = 15;
   localparam int EV_EXT      = 14;
   localparam int EV_CODE_MSB = 7;
   localparam int EV_CODE_LSB = 0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR_DATA = 2'd1,
      WR_HEAD = 2'd2
   } state_t;

   function automatic logic [15:0] make_event(input logic rel,
                                              input logic ext,
                                              input logic [7:0] code);
      logic [15:0] ev;
      ev = '0;
      ev[EV_REL] = rel;
      ev[EV_EXT] = ext;
      ev[EV_CODE_MSB:EV_CODE_LSB] = code;
      return ev;
   endfunction

endpackage

// File: rtl/kbd_io_bridge_fifo.sv
// kbd_fifo
// Small synchronous show-ahead FIFO for 16-bit key events.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   pop_data        entry at the head of the queue
//   full, empty     occupancy flags
//   count           number of stored entries
module kbd_fifo #(
   parameter int FIFO_DEPTH_LOG2 = 3
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic [15:0]                push_data,
   input  logic                       pop,
   output logic [15:0]                pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [FIFO_DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

   logic [15:0]                mem [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
   logic                       do_push;
   logic                       do_pop;

   assign full     = (count == (FIFO_DEPTH_LOG2+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   // Pointers wrap naturally at the power-of-two depth; count tracks
   // occupancy so full and empty never need pointer comparison.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/kbd_io_bridge.sv
// kbd_io_bridge
// Turns PS/2 scan codes from kbctrl into 16-bit key events (break and
// extended prefixes folded in), queues them, and writes each one into a
// ring buffer in data memory followed by the updated head index.
// Ports:
//   CLK, RST     system clock, synchronous active-high reset
//   KCODE        scan code, stable while KCOME is high
//   KCOME        code-valid level from the keyboard clock domain
//   CLR_OVF      pulse that clears OVERFLOW
//   WADDR_IO     memory write address
//   DATA_IN_IO   memory write data
//   MW_IO_ON     memory write enable, one word per high cycle
//   OVERFLOW     sticky dropped-event flag
//   PENDING      events waiting in the FIFO
module kbd_io_bridge
   import kbd_io_pkg::*;
#(
   parameter logic [15:0] BUF_BASE        = 16'h0F00,
   parameter int          BUF_DEPTH_LOG2  = 4,
   parameter logic [15:0] HEAD_ADDR       = 16'h0EFF,
   parameter int          FIFO_DEPTH_LOG2 = 3
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [7:0]                 KCODE,
   input  logic                       KCOME,
   input  logic                       CLR_OVF,
   output logic [15:0]                WADDR_IO,
   output logic [15:0]                DATA_IN_IO,
   output logic                       MW_IO_ON,
   output logic                       OVERFLOW,
   output logic [FIFO_DEPTH_LOG2:0]   PENDING
);

   logic        sync1, sync2, sync3;
   logic        rise_q;
   logic        rel_flag, ext_flag;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [15:0] fifo_data;
   logic [15:0] push_data;
   logic        drop;

   state_t                    state, state_next;
   logic [BUF_DEPTH_LOG2-1:0] head, head_next, head_inc;
   logic                      mw_next;
   logic [15:0]               waddr_next, data_next;

   // A capture is a non-prefix code arriving one cycle after the registered
   // edge detect; prefixes only arm the flags for the following code.
   assign fifo_push = rise_q && (KCODE != KC_BREAK) && (KCODE != KC_EXT);
   assign push_data = make_event(rel_flag, ext_flag, KCODE);
   assign drop      = fifo_push & fifo_full;

   // Synchroniser, registered rising-edge detect, prefix flags and the
   // sticky overflow flag. A drop still consumes the prefix flags, and a
   // drop outranks a simultaneous clear.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sync3    <= 1'b0;
         rise_q   <= 1'b0;
         rel_flag <= 1'b0;
         ext_flag <= 1'b0;
         OVERFLOW <= 1'b0;
      end else begin
         sync1  <= KCOME;
         sync2  <= sync1;
         sync3  <= sync2;
         rise_q <= sync2 & ~sync3;
         if (rise_q) begin
            if (KCODE == KC_BREAK) begin
               rel_flag <= 1'b1;
            end else if (KCODE == KC_EXT) begin
               ext_flag <= 1'b1;
            end else begin
               rel_flag <= 1'b0;
               ext_flag <= 1'b0;
            end
         end
         if (drop)         OVERFLOW <= 1'b1;
         else if (CLR_OVF) OVERFLOW <= 1'b0;
      end
   end

   kbd_fifo #(
      .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
   ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_data),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (PENDING)
   );

   assign head_inc = head + 1'b1;

   // Writer next-state logic. Output values are computed for the state being
   // entered so the memory port is fully registered; the head index advances
   // on entry to WR_HEAD so a following WR_DATA already sees the new slot.
   always_comb begin
      state_next = state;
      head_next  = head;
      mw_next    = 1'b0;
      waddr_next = WADDR_IO;
      data_next  = DATA_IN_IO;
      fifo_pop   = 1'b0;
      case (state)
         IDLE, WR_HEAD: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               state_next = WR_DATA;
               mw_next    = 1'b1;
               waddr_next = BUF_BASE + {{(16-BUF_DEPTH_LOG2){1'b0}}, head};
               data_next  = fifo_data;
            end else begin
               state_next = IDLE;
            end
         end
         WR_DATA: begin
            state_next = WR_HEAD;
            mw_next    = 1'b1;
            waddr_next = HEAD_ADDR;
            data_next  = {{(16-BUF_DEPTH_LOG2){1'b0}}, head_inc};
            head_next  = head_inc;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Writer state and registered memory port; reset abandons any write.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         head       <= '0;
         MW_IO_ON   <= 1'b0;
         WADDR_IO   <= '0;
         DATA_IN_IO <= '0;
      end else begin
         state      <= state_next;
         head       <= head_next;
         MW_IO_ON   <= mw_next;
         WADDR_IO   <= waddr_next;
         DATA_IN_IO <= data_next;
      end
   end

endmodule

// File: tb/tb_kbd_io_bridge.sv
// tb_kbd_io_bridge
// Directed bench for kbd_io_bridge: reset state, single-event latency,
// prefix folding, ring wrap, FIFO overflow and clear priority, reset during
// a write, and a held KCOME level.
module tb_kbd_io_bridge;

   logic        clk;
   logic        rst;
   logic [7:0]  kcode;
   logic        kcome;
   logic        clr_ovf;
   logic [15:0] waddr_io;
   logic [15:0] data_in_io;
   logic        mw_io_on;
   logic        overflow;
   logic [3:0]  pending;

   int          vectors;
   int          miscompares;
   logic [3:0]  head_exp;

   kbd_io_bridge dut (
      .CLK        (clk),
      .RST        (rst),
      .KCODE      (kcode),
      .KCOME      (kcome),
      .CLR_OVF    (clr_ovf),
      .WADDR_IO   (waddr_io),
      .DATA_IN_IO (data_in_io),
      .MW_IO_ON   (mw_io_on),
      .OVERFLOW   (overflow),
      .PENDING    (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every step lands on a falling edge, away from the active edge.
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] actual,
                              input logic [15:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
      end
   endtask

   // One KCOME pulse, then enough idle cycles for the code to be captured
   // before KCODE may change again.
   task automatic applyStimulus(input logic [7:0] code);
      kcode = code;
      kcome = 1'b1;
      tick();
      kcome = 1'b0;
      repeat (4) tick();
   endtask

   // Waits (bounded) for a data write, then checks it and the head write.
   task automatic expectEvent(input string tag, input logic [15:0] ev);
      int waited;
      waited = 0;
      while (!mw_io_on && waited < 20) begin
         tick();
         waited++;
      end
      checkOutput({tag, "_seen"}, {15'd0, mw_io_on}, 16'd1);
      if (mw_io_on) begin
         checkOutput({tag, "_addr"}, waddr_io, 16'h0F00 + {12'd0, head_exp});
         checkOutput({tag, "_data"}, data_in_io, ev);
         tick();
         head_exp = head_exp + 4'd1;
         checkOutput({tag, "_hwe"}, {15'd0, mw_io_on}, 16'd1);
         checkOutput({tag, "_haddr"}, waddr_io, 16'h0EFF);
         checkOutput({tag, "_hdata"}, data_in_io, {12'd0, head_exp});
         tick();
      end
   endtask

   task automatic countWrites(input int cycles, output int writes);
      writes = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (mw_io_on) writes++;
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected end");
      $fatal(1);
   end

   initial begin
      int          writes;
      logic [15:0] first_data;
      logic [7:0]  c;

      vectors     = 0;
      miscompares = 0;
      head_exp    = 4'd0;
      rst         = 1'b1;
      kcode       = 8'h00;
      kcome       = 1'b0;
      clr_ovf     = 1'b0;

      // Reset state
      repeat (3) tick();
      checkOutput("rst_mw", {15'd0, mw_io_on}, 16'd0);
      checkOutput("rst_waddr", waddr_io, 16'h0000);
      checkOutput("rst_data", data_in_io, 16'h0000);
      checkOutput("rst_ovf", {15'd0, overflow}, 16'd0);
      checkOutput("rst_pending", {12'd0, pending}, 16'd0);
      rst = 1'b0;
      tick();

      // Single make with exact latency (KCOME first sampled at edge n)
      kcode = 8'h1C;
      kcome = 1'b1;
      tick();
      kcome = 1'b0;
      tick();
      tick();
      checkOutput("lat_n2_pending", {12'd0, pending}, 16'd0);
      tick();
      checkOutput("lat_n3_pending", {12'd0, pending}, 16'd1);
      checkOutput("lat_n3_mw", {15'd0, mw_io_on}, 16'd0);
      tick();
      checkOutput("lat_n4_mw", {15'd0, mw_io_on}, 16'd1);
      checkOutput("lat_n4_addr", waddr_io, 16'h0F00);
      checkOutput("lat_n4_data", data_in_io, 16'h001C);
      checkOutput("lat_n4_pending", {12'd0, pending}, 16'd0);
      tick();
      checkOutput("lat_n5_mw", {15'd0, mw_io_on}, 16'd1);
      checkOutput("lat_n5_addr", waddr_io, 16'h0EFF);
      checkOutput("lat_n5_data", data_in_io, 16'h0001);
      tick();
      checkOutput("lat_n6_mw", {15'd0, mw_io_on}, 16'd0);
      checkOutput("lat_hold_addr", waddr_io, 16'h0EFF);
      checkOutput("lat_hold_data", data_in_io, 16'h0001);
      head_exp = 4'd1;

      // Break and extended break; prefixes must not produce writes
      applyStimulus(8'hF0);
      applyStimulus(8'h1C);
      expectEvent("brk", 16'h801C);
      applyStimulus(8'hE0);
      applyStimulus(8'hF0);
      applyStimulus(8'h75);
      expectEvent("extbrk", 16'hC075);
      countWrites(10, writes);
      checkOutput("prefix_nowrite", 16'(writes), 16'd0);

      // Ring wrap over 17 events from a fresh head
      rst = 1'b1;
      tick();
      rst = 1'b0;
      head_exp = 4'd0;
      for (int i = 0; i < 17; i++) begin
         c = 8'h10 + 8'(i);
         applyStimulus(c);
         expectEvent("wrap", {8'h00, c});
      end

      // Overflow: writer starved by forcing the FIFO to look empty
      force dut.fifo_empty = 1'b1;
      kcode = 8'h2A;
      for (int i = 0; i < 9; i++) begin
         kcome = 1'b1;
         tick();
         kcome = 1'b0;
         tick();
      end
      checkOutput("ovf_full_pending", {12'd0, pending}, 16'd8);
      checkOutput("ovf_full_flag", {15'd0, overflow}, 16'd0);
      tick();
      tick();
      checkOutput("ovf_drop_flag", {15'd0, overflow}, 16'd1);
      checkOutput("ovf_drop_pending", {12'd0, pending}, 16'd8);
      checkOutput("ovf_no_write", {15'd0, mw_io_on}, 16'd0);
      kcome = 1'b1;
      tick();
      kcome = 1'b0;
      tick();
      tick();
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checkOutput("ovf_clr_vs_drop", {15'd0, overflow}, 16'd1);
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      checkOutput("ovf_clr_alone", {15'd0, overflow}, 16'd0);
      release dut.fifo_empty;
      for (int i = 0; i < 8; i++) begin
         expectEvent("drain", 16'h002A);
      end
      checkOutput("drain_pending", {12'd0, pending}, 16'd0);

      // Reset during a data write
      applyStimulus(8'h44);
      checkOutput("rstmid_pre_mw", {15'd0, mw_io_on}, 16'd1);
      rst = 1'b1;
      tick();
      checkOutput("rstmid_mw", {15'd0, mw_io_on}, 16'd0);
      checkOutput("rstmid_pending", {12'd0, pending}, 16'd0);
      rst = 1'b0;
      head_exp = 4'd0;
      tick();
      checkOutput("rstmid_nohead", {15'd0, mw_io_on}, 16'd0);
      applyStimulus(8'h45);
      expectEvent("post_rst", 16'h0045);

      // KCOME held high for 50 cycles yields one event
      kcode = 8'h33;
      kcome = 1'b1;
      writes = 0;
      first_data = 16'hFFFF;
      for (int i = 0; i < 60; i++) begin
         if (i == 50) kcome = 1'b0;
         tick();
         if (mw_io_on) begin
            if (writes == 0) first_data = data_in_io;
            writes++;
         end
      end
      checkOutput("held_writes", 16'(writes), 16'd2);
      checkOutput("held_data", first_data, 16'h0033);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
